// File: rtl/i2s_tx_if.sv
// Sample-pair handshake between an audio source and i2s_tx.
// A pair transfers on a clk edge where din_valid and din_ready are both 1; din_ready never depends on din_valid.
interface i2s_tx_if #(
  parameter int DW = 16
);
  logic [DW-1:0] din_left;
  logic [DW-1:0] din_right;
  logic          din_valid;
  logic          din_ready;

  modport master (output din_left, output din_right, output din_valid, input din_ready);
  modport slave  (input din_left, input din_right, input din_valid, output din_ready);
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: divides clk into BCLK, serialises one held stereo pair per frame, standard or left-justified.
// Optional macro I2S_TX_REPEAT_EN: an underflow frame resends the last loaded pair instead of zeros.
module i2s_tx #(
  parameter int DW  = 16,
  parameter int DIV = 2
) (
  input  logic     clk,
  input  logic     rst,
  i2s_tx_if.slave  smp,
  input  logic     ws_align,
  output logic     i2s_clk,
  output logic     i2s_ws,
  output logic     i2s_dout,
  output logic     underflow
);
  localparam int KW = $clog2(2 * DW);
  localparam int CW = $clog2(DIV);
  localparam logic [KW-1:0] K_LAST = KW'(2 * DW - 1);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);

  logic [CW-1:0]   div_cnt;
  logic            div_wrap;
  logic            fall;
  logic            frame_start;
  logic [KW-1:0]   k;
  logic [KW-1:0]   k_next;

  logic            hold_full;
  logic [DW-1:0]   hold_l;
  logic [DW-1:0]   hold_r;
  logic            accept;
  logic            starved;

  logic [2*DW-1:0] sreg;
  logic [2*DW-1:0] new_pair;
  logic [2*DW-1:0] fill_pair;
  logic            lj_bit;
  logic            prev_lj;
  logic            mode;
  logic            mode_next;

  assign div_wrap    = (div_cnt == C_LAST);
  assign fall        = div_wrap & i2s_clk;
  assign frame_start = fall & (k == K_LAST);
  assign k_next      = (k == K_LAST) ? '0 : k + 1'b1;

  assign smp.din_ready = ~hold_full;
  assign accept        = smp.din_valid & ~hold_full;
  assign starved       = ~hold_full & ~accept;

`ifdef I2S_TX_REPEAT_EN
  logic [2*DW-1:0] last_pair;
  assign fill_pair = last_pair;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_pair <= '0;
    end else if (frame_start && !starved) begin
      last_pair <= new_pair;
    end
  end
`else
  assign fill_pair = '0;
`endif

  // An accept landing on the frame-start edge with an empty holder feeds this frame directly.
  always_comb begin
    new_pair = fill_pair;
    if (hold_full) begin
      new_pair = {hold_l, hold_r};
    end else if (accept) begin
      new_pair = {smp.din_left, smp.din_right};
    end
  end

  assign lj_bit    = frame_start ? new_pair[2*DW-1] : sreg[2*DW-1];
  assign mode_next = frame_start ? ws_align : mode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      i2s_clk <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      i2s_clk <= ~i2s_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Standard mode replays the previous slot's left-justified bit, giving the one-BCLK delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= K_LAST;
      i2s_ws   <= 1'b1;
      i2s_dout <= 1'b0;
      prev_lj  <= 1'b0;
      mode     <= 1'b0;
      sreg     <= '0;
    end else if (fall) begin
      k        <= k_next;
      i2s_ws   <= (k_next >= KW'(DW));
      i2s_dout <= mode_next ? lj_bit : prev_lj;
      prev_lj  <= lj_bit;
      mode     <= mode_next;
      sreg     <= frame_start ? {new_pair[2*DW-2:0], 1'b0} : {sreg[2*DW-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_l    <= '0;
      hold_r    <= '0;
      underflow <= 1'b0;
    end else begin
      underflow <= frame_start & starved;
      if (frame_start) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold_l    <= smp.din_left;
        hold_r    <= smp.din_right;
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: expected frames go into a queue, a monitor rebuilds frames from BCLK rising edges.
module tb_i2s_tx;
  localparam int DW  = 16;
  localparam int DIV = 2;
`ifdef I2S_TX_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ws_align = 1'b1;
  logic i2s_clk, i2s_ws, i2s_dout, underflow;

  i2s_tx_if #(.DW(DW)) bus ();

  i2s_tx #(.DW(DW), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .smp      (bus),
    .ws_align (ws_align),
    .i2s_clk  (i2s_clk),
    .i2s_ws   (i2s_ws),
    .i2s_dout (i2s_dout),
    .underflow(underflow)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int uf_cnt = 0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // {ws bits, dout bits} of one frame, slot 0 first (MSB)
  function automatic logic [63:0] mk(input logic lj, input logic pb,
                                     input logic [15:0] l, input logic [15:0] r);
    logic [31:0] d;
    d = lj ? {l, r} : {pb, l, r[15:1]};
    return {32'h0000FFFF, d};
  endfunction

  function automatic logic [63:0] uf_frame(input logic lj, input logic pb,
                                           input logic [15:0] l, input logic [15:0] r);
    return REP ? mk(lj, pb, l, r) : mk(lj, pb, 16'h0000, 16'h0000);
  endfunction

  // driver tasks
  task automatic send(input logic [15:0] l, input logic [15:0] r, input bit keep);
    int n;
    n = 0;
    bus.din_left  = l;
    bus.din_right = r;
    bus.din_valid = 1'b1;
    while (!bus.din_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n < 1000), 64'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep) bus.din_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 64'(n < 1000), 64'd1);
  endtask

  task automatic reset_dut(input logic align);
    rst = 1'b1;
    bus.din_valid = 1'b0;
    ws_align = align;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // monitor / scoreboard
  initial begin
    logic [31:0] cap_ws, cap_d;
    int cap_n;
    bit cap_on, prev_bclk, prev_ws, uf_prev;
    cap_ws = '0; cap_d = '0; cap_n = 0;
    cap_on = 0; prev_bclk = 0; prev_ws = 1; uf_prev = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cap_on = 0; cap_n = 0; prev_bclk = 0; prev_ws = 1; uf_prev = 0;
      end else begin
        if (underflow) uf_cnt++;
        if (uf_prev) chk("underflow_width", 64'(underflow), 64'd0);
        uf_prev = underflow;
        if (i2s_clk && !prev_bclk) begin
          if (!cap_on && prev_ws && !i2s_ws) begin
            cap_on = 1;
            cap_n = 0;
          end
          if (cap_on) begin
            cap_ws = {cap_ws[30:0], i2s_ws};
            cap_d  = {cap_d[30:0], i2s_dout};
            cap_n++;
            if (cap_n == 32) begin
              cap_on = 0;
              if (exp_q.size() == 0) begin
                chk("unexpected_frame", {cap_ws, cap_d}, 64'hFFFF_FFFF_FFFF_FFFF);
              end else begin
                chk("frame", {cap_ws, cap_d}, exp_q.pop_front());
              end
            end
          end
          prev_ws = i2s_ws;
        end
        prev_bclk = i2s_clk;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int acc[4];
    bus.din_valid = 1'b0;
    bus.din_left  = '0;
    bus.din_right = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_bclk",  64'(i2s_clk), 64'd0);
    chk("rst_ws",    64'(i2s_ws), 64'd1);
    chk("rst_dout",  64'(i2s_dout), 64'd0);
    chk("rst_ready", 64'(bus.din_ready), 64'd1);
    chk("rst_uf",    64'(underflow), 64'd0);

    // left-justified pair, then two underflow frames
    ws_align = 1'b1;
    rst = 1'b0;
    base = uf_cnt;
    exp_q.push_back(mk(1, 0, 16'hA5C3, 16'h0F01));
    exp_q.push_back(uf_frame(1, 0, 16'hA5C3, 16'h0F01));
    exp_q.push_back(uf_frame(1, 0, 16'hA5C3, 16'h0F01));
    send(16'hA5C3, 16'h0F01, 0);
    wait_empty("drain_lj");
    chk("uf_count_lj", 64'(uf_cnt - base), 64'd2);

    // standard I2S: two pairs then one underflow frame carrying the previous LSB
    reset_dut(1'b0);
    base = uf_cnt;
    exp_q.push_back(mk(0, 0, 16'hA5C3, 16'h0F01));
    exp_q.push_back(mk(0, 1, 16'h1234, 16'h8765));
    exp_q.push_back(uf_frame(0, 1, 16'h1234, 16'h8765));
    send(16'hA5C3, 16'h0F01, 0);
    send(16'h1234, 16'h8765, 0);
    wait_empty("drain_std");
    chk("uf_count_std", 64'(uf_cnt - base), 64'd1);

    // valid held high: first accept coincides with frame start
    reset_dut(1'b1);
    base = uf_cnt;
    exp_q.push_back(mk(1, 0, 16'h8001, 16'h7FFE));
    exp_q.push_back(mk(1, 0, 16'hFFFF, 16'h0000));
    exp_q.push_back(mk(1, 0, 16'h0000, 16'hFFFF));
    exp_q.push_back(mk(1, 0, 16'h3C5A, 16'hC3A5));
    wait_cyc(3);
    send(16'h8001, 16'h7FFE, 1); acc[0] = acc_cyc;
    send(16'hFFFF, 16'h0000, 1); acc[1] = acc_cyc;
    send(16'h0000, 16'hFFFF, 1); acc[2] = acc_cyc;
    send(16'h3C5A, 16'hC3A5, 1); acc[3] = acc_cyc;
    bus.din_valid = 1'b0;
    chk("acc0_cyc", 64'(acc[0]), 64'd4);
    chk("acc_gap1", 64'(acc[1] - acc[0]), 64'd1);
    chk("acc_gap2", 64'(acc[2] - acc[1]), 64'd128);
    chk("acc_gap3", 64'(acc[3] - acc[2]), 64'd128);
    wait_empty("drain_stream");
    chk("uf_count_stream", 64'(uf_cnt - base), 64'd0);

    // asynchronous reset at slot 7, then restart
    reset_dut(1'b1);
    send(16'hA5C3, 16'h0F01, 0);
    send(16'h1234, 16'h8765, 0);
    wait_cyc(34);
    chk("pre_bclk",  64'(i2s_clk), 64'd1);
    chk("pre_ws",    64'(i2s_ws), 64'd0);
    chk("pre_dout",  64'(i2s_dout), 64'd1);
    chk("pre_ready", 64'(bus.din_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("async_bclk",  64'(i2s_clk), 64'd0);
    chk("async_ws",    64'(i2s_ws), 64'd1);
    chk("async_dout",  64'(i2s_dout), 64'd0);
    chk("async_ready", 64'(bus.din_ready), 64'd1);
    chk("async_uf",    64'(underflow), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    base = uf_cnt;
    exp_q.push_back(mk(1, 0, 16'h0000, 16'h0000));
    exp_q.push_back(mk(1, 0, 16'h1357, 16'h2468));
    wait_cyc(3);
    chk("restart_ws_hi", 64'(i2s_ws), 64'd1);
    wait_cyc(4);
    chk("restart_ws_lo", 64'(i2s_ws), 64'd0);
    send(16'h1357, 16'h2468, 0);
    wait_empty("drain_restart");
    chk("uf_count_restart", 64'(uf_cnt - base), 64'd1);

    // ws_align toggled mid-frame takes effect at the next frame
    reset_dut(1'b1);
    base = uf_cnt;
    exp_q.push_back(mk(1, 0, 16'hA5C3, 16'h0F01));
    exp_q.push_back(mk(0, 1, 16'h1234, 16'h8765));
    exp_q.push_back(mk(1, 0, 16'h5A5A, 16'hC3C3));
    fork
      begin
        send(16'hA5C3, 16'h0F01, 0);
        send(16'h1234, 16'h8765, 0);
        send(16'h5A5A, 16'hC3C3, 0);
      end
      begin
        wait_cyc(45);
        ws_align = 1'b0;
        wait_cyc(173);
        ws_align = 1'b1;
      end
    join
    wait_empty("drain_align");
    chk("uf_count_align", 64'(uf_cnt - base), 64'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter: DW, 16, audio sample width per channel in bits.
REQ-002 Parameter: DIV, 2, clk cycles per BCLK half-period; legal range is DIV >= 2.
REQ-003 Port: clk  input  1  system clock; the only clock in the block.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: din_left  input  DW  left sample (two's complement).
REQ-006 Port: din_right  input  DW  right sample.
REQ-007 Port: din_valid  input  1  sample pair offered.
REQ-008 Port: din_ready  output  1  holding register empty; a pair is accepted when din_valid and din_ready are both 1.
REQ-009 Port: ws_align  input  1  0 = standard I2S with one-bit delay; 1 = left-justified.
REQ-010 Port: i2s_clk  output  1  generated BCLK.
REQ-011 Port: i2s_ws  output  1  word select; 0 = left, 1 = right.
REQ-012 Port: i2s_dout  output  1  serial data, MSB first.
REQ-013 Port: underflow  output  1  one-clk pulse at a frame start with no pair held.

Function
REQ-014 The divider counter SHALL count 0..DIV-1 on every clk and wrap to 0; i2s_clk SHALL toggle on the wrap.
- Result: i2s_clk period is 2*DIV clk cycles.
- First rising BCLK edge occurs at clk cycle DIV after reset release.
REQ-015 A "fall event" is the clk cycle in which i2s_clk goes 1->0; i2s_ws, i2s_dout and the slot counter k SHALL update only in that same clk cycle and be registered.
REQ-016 Slot counter k SHALL range 0..2*DW-1, increment on each fall event, and wrap from 2*DW-1 to 0 (frame start).
REQ-017 i2s_ws SHALL equal (k >= DW) in both modes.
REQ-018 Left-justified stream: slot k carries bit DW-1-(k mod DW) of the left sample for k < DW, and of the right sample for k >= DW.
REQ-019 When ws_align=1, i2s_dout SHALL output the left-justified stream.
REQ-020 When ws_align=0, i2s_dout SHALL output the left-justified stream delayed by one BCLK period.
- Slot 0 then carries the LSB of the previous frame's right sample.
REQ-021 ws_align SHALL be sampled only at frame start; a change mid-frame takes effect at the next frame.
REQ-022 The holding register SHALL load din_left/din_right on accept and deassert din_ready on the next clk.
REQ-023 At frame start, if the holding register is full, the shift register SHALL load the held pair, the holding register SHALL become empty, and din_ready SHALL return to 1 on the next clk.
REQ-024 If an accept and a frame start occur in the same clk with the holding register empty, the new pair SHALL be used for that frame and din_ready SHALL stay 1.
REQ-025 If the holding register is empty at frame start (and no simultaneous accept), underflow SHALL pulse high for exactly one clk, and the frame data SHALL follow REQ-030.
REQ-026 din_ready SHALL be independent of din_valid, so there is no combinational loop.

Reset
REQ-027 While rst=1, and immediately on its assertion regardless of clk, the block SHALL hold:
- i2s_clk=0, k=2*DW-1, i2s_ws=1, i2s_dout=0
- divider=0, holding register empty, din_ready=1, underflow=0
- shift register and last-pair register all zero.
REQ-028 A reset asserted mid-frame SHALL abort the frame; after release, the first fall event SHALL be frame start (k=0).

Configuration
REQ-029 Macro I2S_TX_REPEAT_EN defined: an underflow frame SHALL retransmit the last loaded pair (zeros if no pair has been loaded since reset).
REQ-030 Macro I2S_TX_REPEAT_EN undefined: an underflow frame SHALL transmit all zeros, and the last-pair register SHALL NOT be implemented.

Verification
REQ-031 DW=16, DIV=2, ws_align=1, accept pair L=16'hA5C3, R=16'h0F01 before the first fall event -> clk 8 cycles after the first rising edge is reached... specifically: the first frame captured on BCLK rising edges is WS=0 with 1010010111000011, then WS=1 with 0000111100000001.
REQ-032 Same pair with ws_align=0 -> the WS transition precedes the MSB by one BCLK, and the left MSB (1) appears on slot 1.
REQ-033 No din_valid after the first frame -> underflow pulses once per frame; with I2S_TX_REPEAT_EN the pair A5C3/0F01 repeats, without it all zeros are sent.
REQ-034 din_valid held high continuously -> exactly one pair is consumed per frame (2*DW*2*DIV = 128 clk), din_ready is low between frame starts, and underflow never pulses.
REQ-035 rst asserted at k=7 -> outputs immediately take the REQ-027 values; after release, WS goes 0 at the first fall event at clk 2*DIV, and the frame restarts.
REQ-036 Toggle ws_align at k=10 -> the current frame keeps its old format and the next frame uses the new one.
